// File: rtl/rps_sprite_drawer.sv
// Sprite draw controller for the rock/paper/scissors display: scans one sprite ROM
// and streams one plot per pixel, with a two-stage pipeline covering the ROM read.
module rps_sprite_drawer #(
    parameter int         SPR_W     = 80,
    parameter int         SPR_H     = 120,
    parameter logic [2:0] FG_COLOUR = 3'b010
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic        player,
    input  logic [1:0]  choice,
    output logic [14:0] rom_addr,
    input  logic        rom_q_r,
    input  logic        rom_q_s,
    input  logic        rom_q_p,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAW  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [6:0] SX_LAST = 7'(SPR_W - 1);
    localparam logic [6:0] SY_LAST = 7'(SPR_H - 1);
    localparam logic [7:0] X_OFF   = 8'(SPR_W);

    logic [1:0]  state_r;
    logic        player_r;
    logic [1:0]  choice_r;
    logic [6:0]  sx_r;
    logic [6:0]  sy_r;
    logic [14:0] rom_addr_r;
    logic        flush_cnt_r;
    logic        busy_r;
    logic        done_r;
    logic        s1_valid_r;
    logic [6:0]  s1_sx_r;
    logic [6:0]  s1_sy_r;
    logic [7:0]  x_r;
    logic [6:0]  y_r;
    logic [2:0]  colour_r;
    logic        plot_r;

    logic [6:0]  sx_next_s;
    logic [6:0]  sy_next_s;
    logic [14:0] addr_next_s;
    logic        q_s;
    logic [2:0]  colour_s;

    // Raster-order next pixel and its ROM address (sy*80 + sx as shifts).
    always_comb begin
        sx_next_s = 7'd0;
        sy_next_s = sy_r;
        if (sx_r == SX_LAST) begin
            sx_next_s = 7'd0;
            sy_next_s = sy_r + 7'd1;
        end else begin
            sx_next_s = sx_r + 7'd1;
            sy_next_s = sy_r;
        end
        addr_next_s = {2'b00, sy_next_s, 6'b000000} + {4'b0000, sy_next_s, 4'b0000}
                    + {8'b00000000, sx_next_s};
    end

    // Control FSM: latches the request, walks the sprite, drains the pipeline.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            player_r    <= 1'b0;
            choice_r    <= 2'b00;
            sx_r        <= 7'd0;
            sy_r        <= 7'd0;
            rom_addr_r  <= 15'd0;
            flush_cnt_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r    <= ST_DRAW;
                        player_r   <= player;
                        choice_r   <= choice;
                        sx_r       <= 7'd0;
                        sy_r       <= 7'd0;
                        rom_addr_r <= 15'd0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_DRAW: begin
                    if ((sx_r == SX_LAST) && (sy_r == SY_LAST)) begin
                        state_r     <= ST_FLUSH;
                        flush_cnt_r <= 1'b0;
                    end else begin
                        sx_r       <= sx_next_s;
                        sy_r       <= sy_next_s;
                        rom_addr_r <= addr_next_s;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_r) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        flush_cnt_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // ROM select and colour map; background depends on which half is drawn.
    always_comb begin
        q_s = 1'b0;
        case (choice_r)
            2'b00:   q_s = rom_q_r;
            2'b01:   q_s = rom_q_s;
            default: q_s = rom_q_p;
        endcase
        if (q_s) begin
            colour_s = player_r ? 3'b111 : 3'b000;
        end else begin
            colour_s = FG_COLOUR;
        end
    end

    // Two-stage pixel pipeline aligned with the synchronous ROM read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_r <= 1'b0;
            s1_sx_r    <= 7'd0;
            s1_sy_r    <= 7'd0;
            x_r        <= 8'd0;
            y_r        <= 7'd0;
            colour_r   <= 3'b000;
            plot_r     <= 1'b0;
        end else begin
            s1_valid_r <= (state_r == ST_DRAW);
            s1_sx_r    <= sx_r;
            s1_sy_r    <= sy_r;
            plot_r     <= s1_valid_r;
            if (s1_valid_r) begin
                x_r      <= {1'b0, s1_sx_r} + (player_r ? X_OFF : 8'd0);
                y_r      <= s1_sy_r;
                colour_r <= colour_s;
            end
        end
    end

    assign rom_addr = rom_addr_r;
    assign x        = x_r;
    assign y        = y_r;
    assign colour   = colour_r;
    assign plot     = plot_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule
